// File: rtl/common.sv
// ALU control codes, RV32I opcodes and the issue record shared by the ALU issue stage.
package common;
    localparam int ISSUE_XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0,
                           ALU_SUB  = 4'd1,
                           ALU_SLL  = 4'd2,
                           ALU_SLT  = 4'd3,
                           ALU_SLTU = 4'd4,
                           ALU_XOR  = 4'd5,
                           ALU_SRL  = 4'd6,
                           ALU_SRA  = 4'd7,
                           ALU_OR   = 4'd8,
                           ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011,
                           OPC_OPIMM  = 7'b0010011,
                           OPC_LOAD   = 7'b0000011,
                           OPC_STORE  = 7'b0100011,
                           OPC_LUI    = 7'b0110111,
                           OPC_AUIPC  = 7'b0010111,
                           OPC_JAL    = 7'b1101111,
                           OPC_JALR   = 7'b1100111,
                           OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {LSEL_ZERO, LSEL_RS1, LSEL_PC} lsel_t;
    typedef enum logic [1:0] {RSEL_ZERO, RSEL_RS2, RSEL_IMM, RSEL_FOUR} rsel_t;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} buf_state_t;

    typedef struct packed {
        logic [3:0]            control;
        logic [ISSUE_XLEN-1:0] left;
        logic [ISSUE_XLEN-1:0] right;
        logic [4:0]            rd;
        logic                  rd_we;
        logic                  illegal;
    } alu_issue_t;

    // EX/MEM has the younger result, so it wins over MEM/WB; x0 is hardwired zero.
    function automatic logic [ISSUE_XLEN-1:0] fwd_operand(
        input logic [4:0]            rs,
        input logic [ISSUE_XLEN-1:0] rf_data,
        input logic                  em_we,
        input logic [4:0]            em_rd,
        input logic [ISSUE_XLEN-1:0] em_data,
        input logic                  mw_we,
        input logic [4:0]            mw_rd,
        input logic [ISSUE_XLEN-1:0] mw_data
    );
        if (rs == 5'd0)
            return '0;
        if (em_we && (em_rd == rs))
            return em_data;
        if (mw_we && (mw_rd == rs))
            return mw_data;
        return rf_data;
    endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// Opcode/funct to ALU control code and operand selects.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module alu_ctrl_decode
    import common::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_control,
    output lsel_t      o_left_sel,
    output rsel_t      o_right_sel,
    output logic       o_wb_en,
    output logic       o_illegal
);
    logic w_alt;

    always_comb begin
        o_control   = ALU_ADD;
        o_left_sel  = LSEL_ZERO;
        o_right_sel = RSEL_ZERO;
        o_wb_en     = 1'b0;
        o_illegal   = 1'b0;
        // OP-IMM only uses funct7[5] to pick SRAI; ADDI has no subtract form.
        w_alt       = i_funct7_5 && ((i_opcode == OPC_OP) || (i_funct3 == 3'b101));
        case (i_opcode)
            OPC_OP, OPC_OPIMM: begin
                o_left_sel  = LSEL_RS1;
                o_right_sel = (i_opcode == OPC_OP) ? RSEL_RS2 : RSEL_IMM;
                o_wb_en     = 1'b1;
                case (i_funct3)
                    3'b000:  o_control = w_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  o_control = ALU_SLL;
                    3'b010:  o_control = ALU_SLT;
                    3'b011:  o_control = ALU_SLTU;
                    3'b100:  o_control = ALU_XOR;
                    3'b101:  o_control = w_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  o_control = ALU_OR;
                    default: o_control = ALU_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                o_left_sel  = LSEL_RS1;
                o_right_sel = RSEL_IMM;
                o_wb_en     = (i_opcode == OPC_LOAD);
            end
            OPC_LUI: begin
                o_right_sel = RSEL_IMM;
                o_wb_en     = 1'b1;
            end
            OPC_AUIPC: begin
                o_left_sel  = LSEL_PC;
                o_right_sel = RSEL_IMM;
                o_wb_en     = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_left_sel  = LSEL_PC;
                o_right_sel = RSEL_FOUR;
                o_wb_en     = 1'b1;
            end
            OPC_BRANCH: begin
                o_left_sel  = LSEL_RS1;
                o_right_sel = RSEL_RS2;
                case (i_funct3[2:1])
                    2'b00:   o_control = ALU_SUB;
                    2'b10:   o_control = ALU_SLT;
                    2'b11:   o_control = ALU_SLTU;
                    default: begin
                        o_illegal   = 1'b1;
                        o_left_sel  = LSEL_ZERO;
                        o_right_sel = RSEL_ZERO;
                    end
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue register: forwarding, ALU control, 1-cycle latency, skid buffer
// on valid/ready (SKID_EN=0: single entry, in_ready = !full | out_ready). ALU_ISSUE_PERF_EN adds counters.
module alu_issue_stage
    import common::*;
#(
    parameter int XLEN    = ISSUE_XLEN,
    parameter bit SKID_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            fwd_em_we,
    input  logic [4:0]      fwd_em_rd,
    input  logic [XLEN-1:0] fwd_em_data,
    input  logic            fwd_mw_we,
    input  logic [4:0]      fwd_mw_rd,
    input  logic [XLEN-1:0] fwd_mw_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_control,
    output logic [XLEN-1:0] out_left,
    output logic [XLEN-1:0] out_right,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall
`endif
);
    lsel_t            w_lsel;
    rsel_t            w_rsel;
    logic [3:0]       w_ctrl;
    logic             w_wb_en;
    logic             w_illegal;
    logic [XLEN-1:0]  w_rs1_val, w_rs2_val, w_left, w_right;
    alu_issue_t       w_new, r_main, r_skid;
    buf_state_t       r_state, w_state_nxt;
    logic             w_accept, w_load_main, w_load_skid, w_skid_to_main;

    alu_ctrl_decode u_dec (
        .i_opcode    (in_opcode),
        .i_funct3    (in_funct3),
        .i_funct7_5  (in_funct7_5),
        .o_control   (w_ctrl),
        .o_left_sel  (w_lsel),
        .o_right_sel (w_rsel),
        .o_wb_en     (w_wb_en),
        .o_illegal   (w_illegal)
    );

    assign w_rs1_val = fwd_operand(in_rs1, in_rs1_data, fwd_em_we, fwd_em_rd, fwd_em_data,
                                   fwd_mw_we, fwd_mw_rd, fwd_mw_data);
    assign w_rs2_val = fwd_operand(in_rs2, in_rs2_data, fwd_em_we, fwd_em_rd, fwd_em_data,
                                   fwd_mw_we, fwd_mw_rd, fwd_mw_data);

    always_comb begin
        case (w_lsel)
            LSEL_RS1: w_left = w_rs1_val;
            LSEL_PC:  w_left = in_pc;
            default:  w_left = '0;
        endcase
        case (w_rsel)
            RSEL_RS2:  w_right = w_rs2_val;
            RSEL_IMM:  w_right = in_imm;
            RSEL_FOUR: w_right = XLEN'(4);
            default:   w_right = '0;
        endcase
    end

    always_comb begin
        w_new.control = w_ctrl;
        w_new.left    = w_left;
        w_new.right   = w_right;
        w_new.rd      = in_rd;
        w_new.rd_we   = w_wb_en && (in_rd != 5'd0);
        w_new.illegal = w_illegal;
    end

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = SKID_EN ? (r_state != ST_TWO) : ((r_state == ST_EMPTY) || out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Without the skid entry in_ready blocks accept-while-stalled, so TWO is never reached.
    always_comb begin
        w_state_nxt = r_state;
        if (flush)
            w_state_nxt = ST_EMPTY;
        else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !out_ready)
                        w_state_nxt = ST_TWO;
                    else if (!w_accept && out_ready)
                        w_state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (out_ready) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_accept       = in_valid && in_ready && !flush;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (!flush) begin
            case (r_state)
                ST_EMPTY: w_load_main = w_accept;
                ST_ONE: begin
                    w_load_main = w_accept && out_ready;
                    w_load_skid = w_accept && !out_ready;
                end
                ST_TWO:   w_skid_to_main = out_ready;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main)
                r_main <= w_new;
            else if (w_skid_to_main)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= w_new;
        end
    end

    assign out_control = r_main.control;
    assign out_left    = r_main.left;
    assign out_right   = r_main.right;
    assign out_rd      = r_main.rd;
    assign out_rd_we   = r_main.rd_we;
    assign out_illegal = r_main.illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_issued, r_perf_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (out_valid && out_ready)
                r_perf_issued <= r_perf_issued + 32'd1;
            if (out_valid && !out_ready)
                r_perf_stall  <= r_perf_stall + 32'd1;
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model checked every cycle, plus directed literal checks.
module tb_alu_issue_stage;
    import common::*;

    logic        clk, reset, flush;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
    logic        fwd_em_we, fwd_mw_we;
    logic [4:0]  fwd_em_rd, fwd_mw_rd;
    logic [31:0] fwd_em_data, fwd_mw_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_control;
    logic [31:0] out_left, out_right;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .fwd_em_we(fwd_em_we), .fwd_em_rd(fwd_em_rd), .fwd_em_data(fwd_em_data),
        .fwd_mw_we(fwd_mw_we), .fwd_mw_rd(fwd_mw_rd), .fwd_mw_data(fwd_mw_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_control(out_control), .out_left(out_left), .out_right(out_right),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  control;
        logic [31:0] left;
        logic [31:0] right;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    exp_t q[$];

    function automatic logic [31:0] src(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (fwd_em_we && fwd_em_rd == rs) return fwd_em_data;
        if (fwd_mw_we && fwd_mw_rd == rs) return fwd_mw_data;
        return rf;
    endfunction

    function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return alt ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic exp_t model_issue();
        exp_t e;
        logic [31:0] a, b;
        a = src(in_rs1, in_rs1_data);
        b = src(in_rs2, in_rs2_data);
        e = '{control: ALU_ADD, left: 32'd0, right: 32'd0, rd: in_rd, rd_we: 1'b0, illegal: 1'b0};
        if (in_opcode == OPC_OP) begin
            e.control = arith(in_funct3, in_funct7_5); e.left = a; e.right = b; e.rd_we = 1'b1;
        end else if (in_opcode == OPC_OPIMM) begin
            e.control = arith(in_funct3, in_funct7_5 && in_funct3 == 3'd5);
            e.left = a; e.right = in_imm; e.rd_we = 1'b1;
        end else if (in_opcode == OPC_LOAD || in_opcode == OPC_STORE) begin
            e.left = a; e.right = in_imm; e.rd_we = (in_opcode == OPC_LOAD);
        end else if (in_opcode == OPC_LUI) begin
            e.right = in_imm; e.rd_we = 1'b1;
        end else if (in_opcode == OPC_AUIPC) begin
            e.left = in_pc; e.right = in_imm; e.rd_we = 1'b1;
        end else if (in_opcode == OPC_JAL || in_opcode == OPC_JALR) begin
            e.left = in_pc; e.right = 32'd4; e.rd_we = 1'b1;
        end else if (in_opcode == OPC_BRANCH && in_funct3[2:1] != 2'b01) begin
            e.left = a; e.right = b;
            e.control = !in_funct3[2] ? ALU_SUB : (in_funct3[1] ? ALU_SLTU : ALU_SLT);
        end else begin
            e.illegal = 1'b1;
        end
        if (in_rd == 0) e.rd_we = 1'b0;
        return e;
    endfunction

    // Two-deep FIFO view of the stage: accept while fewer than two held, flush empties it.
    always @(posedge clk or posedge reset) begin : model_upd
        bit acc, drn;
        if (reset || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(model_issue());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (reset) begin
                chk("rst_out_valid", 80'(out_valid), 80'(1'b0));
                chk("rst_in_ready", 80'(in_ready), 80'(1'b1));
            end else begin
                chk("in_ready", 80'(in_ready), 80'(q.size() < 2));
                chk("out_valid", 80'(out_valid), 80'(q.size() > 0));
                if (q.size() > 0 && out_valid)
                    chk("issue", 80'({out_control, out_left, out_right, out_rd, out_rd_we, out_illegal}),
                        80'(q[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; in_opcode = 0; in_funct3 = 0; in_funct7_5 = 0;
        in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0; in_rd = 0;
        fwd_em_we = 0; fwd_em_rd = 0; fwd_em_data = 0; fwd_mw_we = 0; fwd_mw_rd = 0; fwd_mw_data = 0;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        in_valid = 1; in_opcode = opc; in_funct3 = f3; in_funct7_5 = f75;
        in_rs1 = rs1; in_rs2 = rs2; in_rs1_data = d1; in_rs2_data = d2;
        in_imm = imm; in_pc = pc; in_rd = rd;
    endtask

    logic [6:0] opc_tab [0:10] = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC,
                                   OPC_JAL, OPC_JALR, OPC_BRANCH, 7'b0001111, 7'b1110011};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        out_ready = 1;
        reset = 1;
        chk_en = 1;
        tick(); tick();
        chk("reset_ctrl", 80'(out_control), 80'(ALU_ADD));
        chk("reset_left", 80'(out_left), 80'(0));
        chk("reset_right", 80'(out_right), 80'(0));
        chk("reset_valid", 80'(out_valid), 80'(0));
        chk("reset_in_ready", 80'(in_ready), 80'(1));
        reset = 0;
        tick();

        // ADD x3,x1,x2
        drive(OPC_OP, 3'b000, 0, 5'd1, 5'd2, 32'd5, 32'd7, 0, 0, 5'd3);
        tick(); in_valid = 0;
        chk("t1_issue", 80'({out_valid, out_control, out_left, out_right, out_rd, out_rd_we}),
            80'({1'b1, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1}));
        tick();

        // SRAI then ADDI with funct7[5] set; then SUB
        drive(OPC_OPIMM, 3'b101, 1, 5'd1, 5'd0, 32'h8000_0000, 0, 32'd4, 0, 5'd5);
        tick();
        chk("t2_srai", 80'({out_control, out_right}), 80'({ALU_SRA, 32'd4}));
        drive(OPC_OPIMM, 3'b000, 1, 5'd1, 5'd0, 32'd10, 0, 32'd4, 0, 5'd6);
        tick();
        chk("t2_addi", 80'({out_control, out_left, out_right}), 80'({ALU_ADD, 32'd10, 32'd4}));
        drive(OPC_OP, 3'b000, 1, 5'd1, 5'd2, 32'd9, 32'd3, 0, 0, 5'd7);
        tick(); in_valid = 0;
        chk("t2_sub", 80'(out_control), 80'(ALU_SUB));
        tick();

        // forwarding priority and x0
        fwd_em_we = 1; fwd_em_rd = 5'd2; fwd_em_data = 32'hAA;
        fwd_mw_we = 1; fwd_mw_rd = 5'd2; fwd_mw_data = 32'hBB;
        drive(OPC_OP, 3'b000, 0, 5'd2, 5'd2, 32'h11, 32'h22, 0, 0, 5'd7);
        tick();
        chk("t3_em_wins", 80'({out_left, out_right}), 80'({32'hAA, 32'hAA}));
        drive(OPC_OP, 3'b000, 0, 5'd0, 5'd2, 32'h11, 32'h22, 0, 0, 5'd7);
        fwd_em_we = 0;
        tick();
        chk("t3_x0_and_mw", 80'({out_left, out_right}), 80'({32'h0, 32'hBB}));
        drive(OPC_OPIMM, 3'b000, 0, 5'd1, 5'd0, 32'h1, 0, 32'h5, 0, 5'd0);
        tick(); idle();
        chk("t3_rd0_no_we", 80'(out_rd_we), 80'(0));
        tick();

        // backpressure: two held, third refused, drain in order
        out_ready = 0;
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd1, 0, 5'd1); tick();
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd2, 0, 5'd2); tick();
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd3, 0, 5'd3);
        chk("t4_full", 80'({in_ready, out_valid, out_right}), 80'({1'b0, 1'b1, 32'd1}));
        tick();
        chk("t4_stable", 80'({in_ready, out_valid, out_right, out_rd}), 80'({1'b0, 1'b1, 32'd1, 5'd1}));
        in_valid = 0; out_ready = 1;
        tick();
        chk("t4_second", 80'({out_valid, out_right, out_rd}), 80'({1'b1, 32'd2, 5'd2}));
        tick();
        chk("t4_empty", 80'(out_valid), 80'(0));

        // flush while two held, with a same-cycle input
        out_ready = 0;
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd4, 0, 5'd4); tick();
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd5, 0, 5'd5); tick();
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd6, 0, 5'd6); flush = 1;
        tick(); flush = 0; in_valid = 0;
        chk("t5_flushed", 80'({out_valid, in_ready}), 80'({1'b0, 1'b1}));
        tick();
        chk("t5_dropped", 80'(out_valid), 80'(0));
        out_ready = 1;
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd7, 0, 5'd7); flush = 1;
        tick(); flush = 0; in_valid = 0;
        chk("t5_flush_beats_accept", 80'(out_valid), 80'(0));

        // illegal encodings
        drive(OPC_BRANCH, 3'b010, 0, 5'd1, 5'd2, 32'd1, 32'd2, 0, 0, 5'd3);
        tick();
        chk("t6_br010", 80'({out_illegal, out_rd_we, out_left}), 80'({1'b1, 1'b0, 32'd0}));
        drive(7'b1111111, 3'b000, 0, 5'd1, 5'd2, 32'd1, 32'd2, 32'd9, 32'd8, 5'd3);
        tick(); in_valid = 0;
        chk("t6_badopc", 80'({out_illegal, out_rd_we, out_control, out_left, out_right}),
            80'({1'b1, 1'b0, ALU_ADD, 32'd0, 32'd0}));
        drive(OPC_JAL, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 5'd1);
        tick(); in_valid = 0;
        chk("t6_jal", 80'({out_control, out_left, out_right}), 80'({ALU_ADD, 32'hFFFF_FFFC, 32'd4}));
        tick();

        // async reset while stalled with two held
        out_ready = 0;
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd8, 0, 5'd8); tick();
        drive(OPC_LUI, 0, 0, 0, 0, 0, 0, 32'd9, 0, 5'd9); tick();
        in_valid = 0;
        #2 reset = 1;
        #1 chk("t6_async_reset", 80'({out_valid, in_ready}), 80'({1'b0, 1'b1}));
        tick(); reset = 0; out_ready = 1;
        tick();

        // sweep of opcode/funct3 combinations under mixed handshaking
        for (int j = 0; j < 11; j++) begin
            for (int f = 0; f < 8; f++) begin
                int i;
                i = j * 8 + f;
                drive(opc_tab[j], 3'(f), 1'((f + j) % 2), 5'((i * 7) % 32), 5'((i * 5) % 32),
                      32'h1000_0000 + 32'(i * 3), 32'h2000_0000 + 32'(i * 11),
                      32'hFFFF_F000 + 32'(i), 32'hFFFF_FFF0 + 32'(i * 4), 5'(i % 32));
                in_valid    = (i % 5 != 4);
                out_ready   = (i % 3 != 2);
                flush       = (i % 17 == 16);
                fwd_em_we   = (i % 4 == 1); fwd_em_rd = in_rs1; fwd_em_data = 32'hE000_0000 + 32'(i);
                fwd_mw_we   = (i % 3 == 0); fwd_mw_rd = in_rs2; fwd_mw_data = 32'hD000_0000 + 32'(i);
                tick();
            end
        end
        idle();
        out_ready = 1;
        for (int k = 0; k < 10 && out_valid; k++) tick();
        chk("final_drain", 80'(out_valid), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
